// File: rtl/lc3_int_ctrl_if.sv
// Request/config bus between the LC-3 control unit and lc3_int_ctrl.
// master = control unit side, slave = interrupt controller side.
interface lc3_int_ctrl_if #(
   parameter int NUM_IRQ = 8,
   parameter int PRIO_W  = 3,
   parameter int VEC_W   = 8
);
   logic [NUM_IRQ-1:0] irq;
   logic               cfg_we;
   logic [3:0]         cfg_idx;
   logic               cfg_en;
   logic [PRIO_W-1:0]  cfg_prio;
   logic [PRIO_W-1:0]  cur_prio;
   logic               exc_priv;
   logic               exc_ill;
   logic               int_ack;
   logic               int_done;
   logic               INT;
   logic [VEC_W-1:0]   int_vector;
   logic [PRIO_W-1:0]  int_prio;
   logic               int_is_exc;
   logic [3:0]         nest_cnt;
   logic [NUM_IRQ-1:0] pending;

   modport master (
      output irq, cfg_we, cfg_idx, cfg_en, cfg_prio,
      output cur_prio, exc_priv, exc_ill,
      output int_ack, int_done,
      input  INT, int_vector, int_prio,
      input  int_is_exc, nest_cnt, pending
   );

   modport slave (
      input  irq, cfg_we, cfg_idx, cfg_en, cfg_prio,
      input  cur_prio, exc_priv, exc_ill,
      input  int_ack, int_done,
      output INT, int_vector, int_prio,
      output int_is_exc, nest_cnt, pending
   );
endinterface

// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt/exception front-end: latches device requests and
// exceptions, arbitrates, and holds one INT request until acked.
// Ports: clk, rst (async, active-high), bus (lc3_int_ctrl_if.slave).
module lc3_int_ctrl #(
   parameter int               NUM_IRQ   = 8,
   parameter int               PRIO_W    = 3,
   parameter int               VEC_W     = 8,
   parameter logic [VEC_W-1:0] VEC_BASE  = 8'h80,
   parameter bit               EDGE_MODE = 1'b1,
   parameter int               MAX_NEST  = 4
) (
   input  logic         clk,
   input  logic         rst,
   lc3_int_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACKD = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [NUM_IRQ-1:0] r_irq_q;
   logic [NUM_IRQ-1:0] r_pend;
   logic [NUM_IRQ-1:0] r_en;
   logic [PRIO_W-1:0]  r_prio [NUM_IRQ];
   logic               r_exc_priv;
   logic               r_exc_ill;
   logic [3:0]         r_nest;
   logic [VEC_W-1:0]   r_vec;
   logic [PRIO_W-1:0]  r_iprio;
   logic               r_is_exc;
   logic [3:0]         r_win;

   logic [NUM_IRQ-1:0] w_pend;
   logic [NUM_IRQ-1:0] w_elig;
   logic [NUM_IRQ-1:0] w_clr;
   logic               w_nest_ok;
   logic               w_found;
   logic [PRIO_W-1:0]  w_best;
   logic [3:0]         w_best_idx;
   logic               w_cand;
   logic               w_cand_exc;
   logic [VEC_W-1:0]   w_cand_vec;
   logic [PRIO_W-1:0]  w_cand_prio;
   logic [3:0]         w_cand_win;
   logic               w_ack;
   logic               w_dev_ack;
   logic               w_exc_ack;

   assign w_pend    = EDGE_MODE ? r_pend : bus.irq;
   assign w_nest_ok = (r_nest < 4'(MAX_NEST));
   assign w_ack     = (r_state == S_REQ) && bus.int_ack;
   assign w_dev_ack = w_ack && !r_is_exc;
   assign w_exc_ack = w_ack && r_is_exc;

   // Strict '>' keeps the lowest index on equal priority.
   always_comb begin
      w_elig     = '0;
      w_found    = 1'b0;
      w_best     = '0;
      w_best_idx = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         w_elig[i] = w_pend[i] && r_en[i] &&
                     (r_prio[i] > bus.cur_prio) && w_nest_ok;
         if (w_elig[i] && (!w_found || r_prio[i] > w_best)) begin
            w_found    = 1'b1;
            w_best     = r_prio[i];
            w_best_idx = 4'(i);
         end
      end
   end

   // Exceptions win over devices; win index 0/1 tags priv/ill.
   always_comb begin
      w_cand      = 1'b1;
      w_cand_exc  = 1'b1;
      w_cand_vec  = '0;
      w_cand_prio = bus.cur_prio;
      w_cand_win  = 4'd0;
      if (r_exc_priv) begin
         w_cand_vec = '0;
         w_cand_win = 4'd0;
      end else if (r_exc_ill) begin
         w_cand_vec = VEC_W'(1);
         w_cand_win = 4'd1;
      end else begin
         w_cand      = w_found;
         w_cand_exc  = 1'b0;
         w_cand_vec  = VEC_BASE + VEC_W'(w_best_idx);
         w_cand_prio = w_best;
         w_cand_win  = w_best_idx;
      end
   end

   always_comb begin
      w_clr = '0;
      for (int i = 0; i < NUM_IRQ; i++)
         w_clr[i] = w_dev_ack && (r_win == 4'(i));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (w_cand) w_state_nxt = S_REQ;
         S_REQ:  if (bus.int_ack) w_state_nxt = S_ACKD;
         S_ACKD: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.INT        = (r_state == S_REQ);
      bus.int_vector = r_vec;
      bus.int_prio   = r_iprio;
      bus.int_is_exc = r_is_exc;
      bus.nest_cnt   = r_nest;
      bus.pending    = w_pend;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_q    <= '0;
         r_pend     <= '0;
         r_en       <= '0;
         for (int i = 0; i < NUM_IRQ; i++)
            r_prio[i] <= '0;
         r_exc_priv <= 1'b0;
         r_exc_ill  <= 1'b0;
         r_nest     <= 4'd0;
         r_vec      <= '0;
         r_iprio    <= '0;
         r_is_exc   <= 1'b0;
         r_win      <= 4'd0;
      end else begin
         r_irq_q <= bus.irq;
         // A new edge in the ack cycle keeps the bit set.
         if (EDGE_MODE)
            r_pend <= (r_pend & ~w_clr) | (bus.irq & ~r_irq_q);
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.cfg_we && bus.cfg_idx == 4'(i)) begin
               r_en[i]   <= bus.cfg_en;
               r_prio[i] <= bus.cfg_prio;
            end
         end
         r_exc_priv <= bus.exc_priv |
            (r_exc_priv & ~(w_exc_ack && r_win == 4'd0));
         r_exc_ill  <= bus.exc_ill |
            (r_exc_ill & ~(w_exc_ack && r_win == 4'd1));
         // Device ack and done in one cycle cancel out.
         if (w_dev_ack && !bus.int_done)
            r_nest <= r_nest + 4'd1;
         else if (!w_dev_ack && bus.int_done && r_nest != 4'd0)
            r_nest <= r_nest - 4'd1;
         if (r_state == S_IDLE && w_cand) begin
            r_vec    <= w_cand_vec;
            r_iprio  <= w_cand_prio;
            r_is_exc <= w_cand_exc;
            r_win    <= w_cand_win;
         end
      end
   end

endmodule
